map_read_arbiter: RTL and testbench

//  Shares the single read port of the map BROM (worldMap, N*N cells, 3-bit cell value)

---
 rtl/map_read_arbiter_if.sv | 25 ++
 rtl/map_read_arbiter.sv | 95 +++++++++
 tb/tb_map_read_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/map_read_arbiter_if.sv
// rtl/map_read_arbiter_if.sv - engine/BROM side signals of the map read arbiter

interface map_read_arbiter_if #(
  parameter int NUM_DDA = 4,
  parameter int AW      = 10
);
  logic [NUM_DDA-1:0]    map_request_in;
  logic [NUM_DDA*AW-1:0] map_addra_in;
  logic [2:0]            map_data_out;
  logic [NUM_DDA-1:0]    map_data_ready_out;
  logic [AW-1:0]         bram_addr_out;
  logic                  bram_en_out;
  logic [2:0]            bram_data_in;
  logic [NUM_DDA-1:0]    pending_out;

  modport slave (
    input  map_request_in, map_addra_in, bram_data_in,
    output map_data_out, map_data_ready_out, bram_addr_out, bram_en_out, pending_out
  );

  modport master (
    output map_request_in, map_addra_in, bram_data_in,
    input  map_data_out, map_data_ready_out, bram_addr_out, bram_en_out, pending_out
  );
endinterface

// File: rtl/map_read_arbiter.sv
// rtl/map_read_arbiter.sv - round-robin sharing of the map BROM read port between DDA engines
// Requests are latched per engine, one is granted per cycle, and a tag pipe routes results back.

module map_read_arbiter #(
  parameter int NUM_DDA      = 4,
  parameter int N            = 24,
  parameter int BRAM_LATENCY = 2,
  parameter int OOB_VALUE    = 1
)(
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  map_read_arbiter_if.slave bus
);
  localparam int             AW    = $clog2(N*N);
  localparam int             IW    = $clog2(NUM_DDA);
  localparam logic [AW:0]    CELLS = (AW+1)'(N*N);
  localparam logic [2:0]     OOB3  = 3'(OOB_VALUE);

  logic [NUM_DDA-1:0]    r_pending;
  logic [AW-1:0]         r_addr_q [NUM_DDA];
  logic [IW-1:0]         r_rr_ptr;
  logic [BRAM_LATENCY:0] r_tag_v;
  logic [BRAM_LATENCY:0] r_tag_oob;
  logic [IW-1:0]         r_tag_id [BRAM_LATENCY+1];
  logic [AW-1:0]         r_bram_addr;
  logic                  r_bram_en;
  logic [2:0]            r_data;
  logic [NUM_DDA-1:0]    r_ready;

  logic          w_grant_valid;
  logic [IW-1:0] w_grant_id;
  logic [IW-1:0] w_cand;
  logic          w_oob;

  // Scan from farthest to nearest so the nearest pending engine after rr_ptr wins.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = '0;
    w_cand        = '0;
    for (int k = NUM_DDA; k >= 1; k--) begin
      w_cand = IW'((int'(r_rr_ptr) + k) % NUM_DDA);
      if (r_pending[w_cand]) begin
        w_grant_valid = 1'b1;
        w_grant_id    = w_cand;
      end
    end
  end

  assign w_oob = ({1'b0, r_addr_q[w_grant_id]} >= CELLS);

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_pending   <= '0;
      r_rr_ptr    <= IW'(NUM_DDA-1);
      r_tag_v     <= '0;
      r_tag_oob   <= '0;
      r_bram_addr <= '0;
      r_bram_en   <= 1'b0;
      r_data      <= '0;
      r_ready     <= '0;
      for (int i = 0; i < NUM_DDA; i++) r_addr_q[i] <= '0;
      for (int k = 0; k <= BRAM_LATENCY; k++) r_tag_id[k] <= '0;
    end else begin
      r_bram_en <= w_grant_valid && !w_oob;
      if (w_grant_valid) begin
        r_pending[w_grant_id] <= 1'b0;
        r_rr_ptr              <= w_grant_id;
        if (!w_oob) r_bram_addr <= r_addr_q[w_grant_id];
      end
      // Capture after the grant clear so a same-cycle re-request stays pending.
      for (int i = 0; i < NUM_DDA; i++) begin
        if (bus.map_request_in[i]) begin
          r_pending[i] <= 1'b1;
          r_addr_q[i]  <= bus.map_addra_in[i*AW +: AW];
        end
      end
      r_tag_v     <= {r_tag_v[BRAM_LATENCY-1:0], w_grant_valid};
      r_tag_oob   <= {r_tag_oob[BRAM_LATENCY-1:0], w_oob};
      r_tag_id[0] <= w_grant_id;
      for (int k = 1; k <= BRAM_LATENCY; k++) r_tag_id[k] <= r_tag_id[k-1];
      if (r_tag_v[BRAM_LATENCY]) begin
        r_data  <= r_tag_oob[BRAM_LATENCY] ? OOB3 : bus.bram_data_in;
        r_ready <= NUM_DDA'(1) << r_tag_id[BRAM_LATENCY];
      end else begin
        r_ready <= '0;
      end
    end
  end

  assign bus.pending_out        = r_pending;
  assign bus.bram_addr_out      = r_bram_addr;
  assign bus.bram_en_out        = r_bram_en;
  assign bus.map_data_out       = r_data;
  assign bus.map_data_ready_out = r_ready;
endmodule

// File: tb/tb_map_read_arbiter.sv
// tb/tb_map_read_arbiter.sv - directed vectors, corner sequences and random traffic vs. a result-queue model

module tb_map_read_arbiter;
  localparam int NUM_DDA = 4;
  localparam int N       = 24;
  localparam int LAT     = 2;
  localparam int OOB     = 1;
  localparam int AW      = 10;
  localparam int CELLS   = N*N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  map_read_arbiter_if #(.NUM_DDA(NUM_DDA), .AW(AW)) bus();

  map_read_arbiter #(
    .NUM_DDA(NUM_DDA), .N(N), .BRAM_LATENCY(LAT), .OOB_VALUE(OOB)
  ) dut (
    .pixel_clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [2:0] brom_val(input int a);
    return 3'((a * 3) % 8);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // BROM with LAT cycles from enable to data
  logic [AW-1:0] brom_pipe [LAT];
  always @(posedge clk) begin
    brom_pipe[0] <= bus.bram_addr_out;
    for (int k = 1; k < LAT; k++) brom_pipe[k] <= brom_pipe[k-1];
  end
  assign bus.bram_data_in = brom_val(int'(brom_pipe[LAT-1]));

  // Reference model: pending flags, stored addresses and a queue of scheduled results
  typedef struct { int due; int id; int val; } res_t;
  res_t               m_q[$];
  bit                 m_pend [NUM_DDA];
  int                 m_addr [NUM_DDA];
  int                 m_rr;
  int                 m_edge = 0;
  logic               exp_en;
  int                 exp_addr;
  logic [NUM_DDA-1:0] exp_ready;
  logic [2:0]         exp_data;
  logic [NUM_DDA-1:0] exp_pend;
  bit                 sb_on = 0;

  always @(posedge clk) begin
    int  g;
    int  idx;
    bit  oob;
    m_edge++;
    if (rst) begin
      for (int i = 0; i < NUM_DDA; i++) begin m_pend[i] = 0; m_addr[i] = 0; end
      m_rr = NUM_DDA - 1;
      m_q.delete();
      exp_en = 0; exp_addr = 0; exp_ready = '0; exp_data = '0;
    end else begin
      exp_ready = '0;
      if (m_q.size() > 0 && m_q[0].due == m_edge) begin
        exp_ready[m_q[0].id] = 1'b1;
        exp_data = 3'(m_q[0].val);
        void'(m_q.pop_front());
      end
      g = -1;
      for (int k = 1; k <= NUM_DDA; k++) begin
        idx = (m_rr + k) % NUM_DDA;
        if (g < 0 && m_pend[idx]) g = idx;
      end
      exp_en = 0;
      if (g >= 0) begin
        oob = (m_addr[g] >= CELLS);
        exp_en = !oob;
        exp_addr = m_addr[g];
        m_pend[g] = 0;
        m_rr = g;
        m_q.push_back('{m_edge + 1 + LAT, g, oob ? OOB : int'(brom_val(m_addr[g]))});
      end
      for (int i = 0; i < NUM_DDA; i++) begin
        if (bus.map_request_in[i]) begin
          m_pend[i] = 1;
          m_addr[i] = int'(bus.map_addra_in[i*AW +: AW]);
        end
      end
    end
    for (int i = 0; i < NUM_DDA; i++) exp_pend[i] = m_pend[i];
  end

  always @(negedge clk) begin
    if (sb_on) begin
      chk("sb_en", bus.bram_en_out, exp_en);
      if (exp_en) chk("sb_addr", bus.bram_addr_out, exp_addr);
      chk("sb_ready", bus.map_data_ready_out, exp_ready);
      if (|exp_ready) chk("sb_data", bus.map_data_out, exp_data);
      chk("sb_pending", bus.pending_out, exp_pend);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int e, input int a);
    bus.map_request_in[e] = 1'b1;
    bus.map_addra_in[e*AW +: AW] = AW'(a);
  endtask

  task automatic clear_req();
    bus.map_request_in = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int                 eng;
    int                 addr;
    logic               exp_en;
    logic [NUM_DDA-1:0] exp_ready;
    logic [2:0]         exp_data;
  } vec_t;

  task automatic run_vec(input vec_t v);
    set_req(v.eng, v.addr);
    tick();
    clear_req();
    tick();
    chk("vec_en", bus.bram_en_out, v.exp_en);
    if (v.exp_en) chk("vec_addr", bus.bram_addr_out, v.addr);
    repeat (LAT) tick();
    chk("vec_ready_early", bus.map_data_ready_out, '0);
    tick();
    chk("vec_ready", bus.map_data_ready_out, v.exp_ready);
    chk("vec_data", bus.map_data_out, v.exp_data);
    tick();
    chk("vec_ready_after", bus.map_data_ready_out, '0);
    repeat (2) tick();
  endtask

  vec_t vecs [5];
  int   grants[$];
  int   cnt_a;
  int   cnt_b;
  int   cnt_c;
  int   bad;
  logic [2:0] got_data;

  initial begin
    vecs[0] = '{0, 25,   1'b1, 4'b0001, 3'd3};
    vecs[1] = '{2, 576,  1'b0, 4'b0100, 3'd1};
    vecs[2] = '{1, 575,  1'b1, 4'b0010, 3'd5};
    vecs[3] = '{3, 1023, 1'b0, 4'b1000, 3'd1};
    vecs[4] = '{3, 0,    1'b1, 4'b1000, 3'd0};

    bus.map_request_in = '0;
    bus.map_addra_in   = '0;
    rst = 1'b1;
    @(posedge clk);
    sb_on = 1;
    tick();
    chk("rst_ready", bus.map_data_ready_out, '0);
    chk("rst_pending", bus.pending_out, '0);
    chk("rst_en", bus.bram_en_out, 1'b0);
    chk("rst_addr", bus.bram_addr_out, '0);
    chk("rst_data", bus.map_data_out, '0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Four simultaneous requests right after reset
    do_reset();
    for (int e = 0; e < NUM_DDA; e++) set_req(e, e + 1);
    tick();
    clear_req();
    for (int j = 0; j < NUM_DDA; j++) begin
      tick();
      chk("all4_en", bus.bram_en_out, 1'b1);
      chk("all4_addr", bus.bram_addr_out, j + 1);
    end
    for (int j = 0; j < NUM_DDA; j++) begin
      chk("all4_ready", bus.map_data_ready_out, NUM_DDA'(1) << j);
      chk("all4_data", bus.map_data_out, brom_val(j + 1));
      tick();
    end
    repeat (4) tick();

    // Engines 1 and 3 re-request on every ready pulse
    set_req(1, 100);
    set_req(3, 300);
    for (int c = 0; c < 40; c++) begin
      tick();
      clear_req();
      if (bus.bram_en_out) grants.push_back(int'(bus.bram_addr_out));
      if (bus.map_data_ready_out[1]) set_req(1, 100);
      if (bus.map_data_ready_out[3]) set_req(3, 300);
    end
    clear_req();
    chk("alt_count_ge6", grants.size() >= 6, 1'b1);
    chk("alt_first", grants[0], 100);
    bad = 0;
    for (int i = 1; i < grants.size(); i++) if (grants[i] == grants[i-1]) bad++;
    chk("alt_repeats", bad, 0);
    repeat (8) tick();

    // Overwrite while pending: engine0 is last in round-robin order
    do_reset();
    run_vec(vecs[4]);
    set_req(0, 5);
    tick();
    clear_req();
    repeat (6) tick();
    set_req(0, 10);
    set_req(1, 20);
    set_req(2, 30);
    tick();
    clear_req();
    set_req(0, 11);
    tick();
    clear_req();
    cnt_a = 0; cnt_b = 0; cnt_c = 0; got_data = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.bram_en_out && bus.bram_addr_out == AW'(10)) cnt_a++;
      if (bus.bram_en_out && bus.bram_addr_out == AW'(11)) cnt_b++;
      if (bus.map_data_ready_out[0]) begin cnt_c++; got_data = bus.map_data_out; end
    end
    chk("ovw_old_addr", cnt_a, 0);
    chk("ovw_new_addr", cnt_b, 1);
    chk("ovw_ready_cnt", cnt_c, 1);
    chk("ovw_data", got_data, brom_val(11));

    // Reset with reads in flight
    set_req(0, 40);
    set_req(1, 41);
    set_req(2, 42);
    tick();
    clear_req();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", bus.map_data_ready_out, '0);
    chk("mid_rst_pending", bus.pending_out, '0);
    chk("mid_rst_en", bus.bram_en_out, 1'b0);
    cnt_a = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.map_data_ready_out != '0) cnt_a++;
    end
    chk("mid_rst_stale", cnt_a, 0);
    run_vec(vecs[0]);

    // Random traffic including out-of-map addresses and protocol violations
    for (int c = 0; c < 400; c++) begin
      clear_req();
      for (int e = 0; e < NUM_DDA; e++)
        if ($urandom_range(0, 99) < 25) set_req(e, int'($urandom_range(0, 1023)));
      tick();
    end
    clear_req();
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
